// File: rtl/ex_mem_stage_pkg.sv
// Shared types and constants for the EX/MEM pipeline register and its overflow-trap FSM.
package ex_mem_stage_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } trap_state_t;

  localparam logic [4:0] EXC_OV = 5'd12;

  // Control bits that make a MEM slot architecturally live; all-zero means bubble.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } mem_ctrl_t;

  localparam mem_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ex_trap_fsm.sv
// Two-state overflow-trap controller: latches EPC/cause, counts traps, and holds
// exc_req until the exception unit acknowledges.
module ex_trap_fsm
  import ex_mem_stage_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter logic [4:0]  OVF_CAUSE = EXC_OV,
  parameter int          CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_trap,
  input  logic              i_exc_ack,
  input  logic [DATA_W-1:0] i_pc,
  output trap_state_t       o_state,
  output logic              o_exc_req,
  output logic [DATA_W-1:0] o_epc,
  output logic [4:0]        o_cause,
  output logic [CNT_W-1:0]  o_ovf_count
);

  trap_state_t       r_state;
  trap_state_t       w_next_state;
  logic              r_exc_req;
  logic [DATA_W-1:0] r_epc;
  logic [4:0]        r_cause;
  logic [CNT_W-1:0]  r_ovf_count;
  logic              w_take_trap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_exc_req <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_exc_req <= (w_next_state == ST_PEND);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN:  if (i_trap)    w_next_state = ST_PEND;
      ST_PEND: if (i_exc_ack) w_next_state = ST_RUN;
      default: w_next_state = ST_RUN;
    endcase
  end

  always_comb begin
    w_take_trap = (r_state == ST_RUN) && i_trap;
    o_state     = r_state;
    o_exc_req   = r_exc_req;
    o_epc       = r_epc;
    o_cause     = r_cause;
    o_ovf_count = r_ovf_count;
  end

  // EPC/cause only move on a fresh trap, so they stay frozen through PEND.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_epc       <= '0;
      r_cause     <= '0;
      r_ovf_count <= '0;
    end else if (w_take_trap) begin
      r_epc   <= i_pc;
      r_cause <= OVF_CAUSE;
      if (!(&r_ovf_count)) r_ovf_count <= r_ovf_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with precise overflow trap, stall/flush, and an
// exc_req/exc_ack handshake (exc_req stays high until exc_ack is seen).
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          REG_AW    = 5,
  parameter logic [4:0]  OVF_CAUSE = EXC_OV,
  parameter int          CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [DATA_W-1:0] ex_alu_z,
  input  logic              ex_overflow,
  input  logic              ex_ovf_trap,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              stall,
  input  logic              flush,
  input  logic              exc_ack,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_z,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_AW-1:0] mem_dest,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_mem_to_reg,
  output logic              exc_req,
  output logic [DATA_W-1:0] epc,
  output logic [4:0]        cause,
  output logic [CNT_W-1:0]  ovf_count,
  output trap_state_t       dbg_state
);

  mem_ctrl_t         r_ctrl;
  logic [DATA_W-1:0] r_alu_z;
  logic [DATA_W-1:0] r_store_data;
  logic [REG_AW-1:0] r_dest;
  trap_state_t       w_state;
  logic              w_trap;
  logic              w_squash;

  assign w_trap   = ex_valid & ex_ovf_trap & ex_overflow & ~stall & ~flush & (w_state == ST_RUN);
  // While PEND every EX instruction is younger than the fault and must not commit.
  assign w_squash = w_trap | (w_state == ST_PEND);

  ex_trap_fsm #(
    .DATA_W    (DATA_W),
    .OVF_CAUSE (OVF_CAUSE),
    .CNT_W     (CNT_W)
  ) u_trap_fsm (
    .clk         (clk),
    .reset       (reset),
    .i_trap      (w_trap),
    .i_exc_ack   (exc_ack),
    .i_pc        (ex_pc),
    .o_state     (w_state),
    .o_exc_req   (exc_req),
    .o_epc       (epc),
    .o_cause     (cause),
    .o_ovf_count (ovf_count)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_ctrl       <= CTRL_BUBBLE;
      r_alu_z      <= '0;
      r_store_data <= '0;
      r_dest       <= '0;
    end else if (!stall) begin
      if (w_squash) begin
        r_ctrl       <= CTRL_BUBBLE;
        r_alu_z      <= '0;
        r_store_data <= '0;
        r_dest       <= '0;
      end else begin
        r_ctrl       <= '{valid:      ex_valid,
                          reg_write:  ex_reg_write,
                          mem_read:   ex_mem_read,
                          mem_write:  ex_mem_write,
                          mem_to_reg: ex_mem_to_reg};
        r_alu_z      <= ex_alu_z;
        r_store_data <= ex_store_data;
        r_dest       <= ex_dest;
      end
    end
  end

  assign mem_valid      = r_ctrl.valid;
  assign mem_reg_write  = r_ctrl.reg_write;
  assign mem_mem_read   = r_ctrl.mem_read;
  assign mem_mem_write  = r_ctrl.mem_write;
  assign mem_mem_to_reg = r_ctrl.mem_to_reg;
  assign mem_alu_z      = r_alu_z;
  assign mem_store_data = r_store_data;
  assign mem_dest       = r_dest;
  assign dbg_state      = w_state;

endmodule
